axi_lite_arbiter: RTL

Two-to-one AXI4-Lite arbiter that shares one downstream AXI4-Lite slave (CLINT, SRAM or the peripheral crossbar) between the instruction-fetch unit and the load/store unit. It allows exactly one transaction, read or write, outstanding at a time. The block grants one requester, routes that requester's channels through to the downstream port, and releases the grant after the response handshake.

---
 rtl/axi_lite_arbiter_if.sv | 40 ++++
 rtl/axi_lite_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite channel bundle shared by the arbiter's requester ports and its downstream port.
// The master modport drives addresses, write data and response readies; the slave modport is its mirror.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-to-one AXI4-Lite arbiter: one transaction outstanding, grant held until its response handshake.
// Channels of the owner pass combinationally to the shared downstream port; the non-owner sees all zeros.
module axi_lite_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic        clk,
  input logic        reset,
  axi_lite_if.slave  s0,
  axi_lite_if.slave  s1,
  axi_lite_if.master m
);
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last;
  logic   ar_done;
  logic   aw_done;
  logic   w_done;

  logic req0;
  logic req1;
  logic winner;
  logic win_arvalid;
  logic in_read;
  logic in_write;
  logic rd0;
  logic rd1;
  logic wr0;
  logic wr1;

  logic [ADDR_W-1:0] own_araddr;
  logic              own_arvalid;
  logic              own_rready;
  logic [ADDR_W-1:0] own_awaddr;
  logic              own_awvalid;
  logic [DATA_W-1:0] own_wdata;
  logic [STRB_W-1:0] own_wstrb;
  logic              own_wvalid;
  logic              own_bready;

  logic ar_hs;
  logic r_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;

  assign req0     = s0.arvalid || s0.awvalid;
  assign req1     = s1.arvalid || s1.awvalid;
  assign in_read  = (state == READ);
  assign in_write = (state == WRITE);
  assign rd0      = in_read && !owner;
  assign rd1      = in_read && owner;
  assign wr0      = in_write && !owner;
  assign wr1      = in_write && owner;

  assign ar_hs = m.arvalid && m.arready;
  assign r_hs  = m.rvalid && m.rready;
  assign aw_hs = m.awvalid && m.awready;
  assign w_hs  = m.wvalid && m.wready;
  assign b_hs  = m.bvalid && m.bready;

  // Winner selection; round-robin favours the requester that was not served last.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = RR_EN ? !last : 1'b0;
    end else if (req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
    win_arvalid = winner ? s1.arvalid : s0.arvalid;
  end

  // Owner-side request channels, selected by the current grant.
  always_comb begin
    if (owner) begin
      own_araddr  = s1.araddr;
      own_arvalid = s1.arvalid;
      own_rready  = s1.rready;
      own_awaddr  = s1.awaddr;
      own_awvalid = s1.awvalid;
      own_wdata   = s1.wdata;
      own_wstrb   = s1.wstrb;
      own_wvalid  = s1.wvalid;
      own_bready  = s1.bready;
    end else begin
      own_araddr  = s0.araddr;
      own_arvalid = s0.arvalid;
      own_rready  = s0.rready;
      own_awaddr  = s0.awaddr;
      own_awvalid = s0.awvalid;
      own_wdata   = s0.wdata;
      own_wstrb   = s0.wstrb;
      own_wvalid  = s0.wvalid;
      own_bready  = s0.bready;
    end
  end

  // Grant state machine; done flags keep each address/data channel to a single handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner   <= winner;
            state   <= win_arvalid ? READ : WRITE;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        READ: begin
          if (ar_hs) begin
            ar_done <= 1'b1;
          end
          if (r_hs) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        WRITE: begin
          if (aw_hs) begin
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            w_done <= 1'b1;
          end
          if (b_hs) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Downstream port: only the channel group matching the state is forwarded, everything else is zero.
  always_comb begin
    m.araddr  = in_read ? own_araddr : '0;
    m.arvalid = in_read && own_arvalid && !ar_done;
    m.rready  = in_read && own_rready;
    m.awaddr  = in_write ? own_awaddr : '0;
    m.awvalid = in_write && own_awvalid && !aw_done;
    m.wdata   = in_write ? own_wdata : '0;
    m.wstrb   = in_write ? own_wstrb : '0;
    m.wvalid  = in_write && own_wvalid && !w_done;
    m.bready  = in_write && own_bready;
  end

  // Requester 0 returns; a stray downstream response outside READ/WRITE is never passed on.
  always_comb begin
    s0.arready = rd0 && m.arready && !ar_done;
    s0.rvalid  = rd0 && m.rvalid;
    s0.rdata   = rd0 ? m.rdata : '0;
    s0.rresp   = rd0 ? m.rresp : 2'b00;
    s0.awready = wr0 && m.awready && !aw_done;
    s0.wready  = wr0 && m.wready && !w_done;
    s0.bvalid  = wr0 && m.bvalid;
    s0.bresp   = wr0 ? m.bresp : 2'b00;
  end

  // Requester 1 returns, mirror of requester 0.
  always_comb begin
    s1.arready = rd1 && m.arready && !ar_done;
    s1.rvalid  = rd1 && m.rvalid;
    s1.rdata   = rd1 ? m.rdata : '0;
    s1.rresp   = rd1 ? m.rresp : 2'b00;
    s1.awready = wr1 && m.awready && !aw_done;
    s1.wready  = wr1 && m.wready && !w_done;
    s1.bvalid  = wr1 && m.bvalid;
    s1.bresp   = wr1 ? m.bresp : 2'b00;
  end
endmodule
